// File: rtl/lsu_pkg.sv
// Shared load/store access-type encodings and classification helpers.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] LB      = 4'd1;
  localparam logic [3:0] LH      = 4'd2;
  localparam logic [3:0] LW      = 4'd3;
  localparam logic [3:0] LBU     = 4'd4;
  localparam logic [3:0] LHU     = 4'd5;
  localparam logic [3:0] SB      = 4'd6;
  localparam logic [3:0] SH      = 4'd7;
  localparam logic [3:0] SW      = 4'd8;

  function automatic logic is_load(input logic [3:0] t);
    return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] t);
    return (t == SB) || (t == SH) || (t == SW);
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed byte/halfword of the RAM word and sign/zero-extends it.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [3:0]      sl_type,
  input  logic [1:0]      off,
  input  logic            misalign,
  input  logic [XLEN-1:0] raw_word,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = raw_word[7:0];
      2'd1: byte_sel = raw_word[15:8];
      2'd2: byte_sel = raw_word[23:16];
      2'd3: byte_sel = raw_word[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = off[1] ? raw_word[31:16] : raw_word[15:0];

  // Misaligned loads return zero so a trapping instruction never writes junk.
  always_comb begin
    load_data = '0;
    if (!misalign) begin
      case (sl_type)
        LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
        LBU:     load_data = {24'h000000, byte_sel};
        LH:      load_data = {{16{half_sel[15]}}, half_sel};
        LHU:     load_data = {16'h0000, half_sel};
        LW:      load_data = raw_word;
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 memory-stage alignment unit: store lane steering, load extraction and
// a sticky capture of the first misaligned access address.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      sl_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data_i,
  input  logic            dram_we,
  input  logic [XLEN-1:0] load_data_i,
  output logic [XLEN-1:0] load_data_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [3:0]      wstrb,
  output logic            misalign_o,
  output logic            fault_valid_o,
  output logic [XLEN-1:0] fault_addr_o,
  input  logic            fault_clr_i
);

  logic [1:0] off;
  logic       misaligned;
  logic [3:0] lane_mask;

  assign off = addr[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (sl_type)
      LH, LHU, SH: misaligned = off[0];
      LW, SW:      misaligned = (off != 2'd0);
      default:     misaligned = 1'b0;
    endcase
  end

  assign misalign_o = (is_load(sl_type) || is_store(sl_type)) && misaligned;

  lsu_load_extract u_load_extract (
    .sl_type   (sl_type),
    .off       (off),
    .misalign  (misalign_o),
    .raw_word  (load_data_i),
    .load_data (load_data_o)
  );

  // Data is still steered for a misaligned store; only the strobes are killed.
  always_comb begin
    store_data_o = '0;
    lane_mask    = 4'b0000;
    case (sl_type)
      SB: begin
        store_data_o = {24'h000000, store_data_i[7:0]} << {off, 3'b000};
        lane_mask    = 4'b0001 << off;
      end
      SH: begin
        store_data_o = {16'h0000, store_data_i[15:0]} << {off[1], 4'b0000};
        lane_mask    = 4'b0011 << off;
      end
      SW: begin
        store_data_o = store_data_i;
        lane_mask    = 4'b1111;
      end
      default: begin
        store_data_o = '0;
        lane_mask    = 4'b0000;
      end
    endcase
  end

  assign wstrb = (dram_we && !misalign_o) ? lane_mask : 4'b0000;

  // Clear wins over capture; only the first misaligned address is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid_o <= 1'b0;
      fault_addr_o  <= '0;
    end else if (fault_clr_i) begin
      fault_valid_o <= 1'b0;
    end else if (misalign_o && !fault_valid_o) begin
      fault_valid_o <= 1'b1;
      fault_addr_o  <= addr;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic
// reference model of the access rules.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sl_type;
  logic [31:0] addr;
  logic [31:0] store_data_i;
  logic        dram_we;
  logic [31:0] load_data_i;
  logic [31:0] load_data_o;
  logic [31:0] store_data_o;
  logic [3:0]  wstrb;
  logic        misalign_o;
  logic        fault_valid_o;
  logic [31:0] fault_addr_o;
  logic        fault_clr_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sl_type       (sl_type),
    .addr          (addr),
    .store_data_i  (store_data_i),
    .dram_we       (dram_we),
    .load_data_i   (load_data_i),
    .load_data_o   (load_data_o),
    .store_data_o  (store_data_o),
    .wstrb         (wstrb),
    .misalign_o    (misalign_o),
    .fault_valid_o (fault_valid_o),
    .fault_addr_o  (fault_addr_o),
    .fault_clr_i   (fault_clr_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] ld, input logic we);
    sl_type      = t;
    addr         = a;
    store_data_i = sd;
    load_data_i  = ld;
    dram_we      = we;
    #1;
  endtask

  // ---------------- reference model ----------------
  // Access size in bytes, then values from plain shifts and arithmetic.
  function automatic void model(input int t, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] ld, input logic we,
                                output logic [31:0] e_ld, output logic [31:0] e_sd,
                                output logic [3:0] e_strb, output logic e_mis);
    int size;
    int off;
    int lane;
    bit is_ld;
    bit is_st;
    bit signed_ld;
    longint v;
    longint lim;
    size = 0;
    if (t == 1 || t == 4 || t == 6) size = 1;
    if (t == 2 || t == 5 || t == 7) size = 2;
    if (t == 3 || t == 8) size = 4;
    off       = int'(a % 4);
    is_ld     = (t >= 1 && t <= 5);
    is_st     = (t >= 6 && t <= 8);
    signed_ld = (t == 1 || t == 2);
    e_mis     = (size != 0) && ((off % size) != 0);
    e_ld      = 32'h0;
    e_sd      = 32'h0;
    e_strb    = 4'h0;
    if (is_ld && !e_mis) begin
      lim = longint'(1) << (8 * size);
      v   = longint'(ld >> (8 * off)) % lim;
      if (signed_ld && v >= lim / 2) v = v - lim;
      e_ld = v[31:0];
    end
    if (is_st) begin
      lim  = longint'(1) << (8 * size);
      lane = (off / size) * size;
      v    = (longint'(sd) % lim) << (8 * lane);
      e_sd = v[31:0];
      if (we && !e_mis) e_strb = 4'(((1 << size) - 1) << off);
    end
  endfunction

  logic [31:0] e_ld, e_sd;
  logic [3:0]  e_strb;
  logic        e_mis;
  logic        m_valid;
  logic [31:0] m_addr;
  int          t_rand;

  initial begin
    rst_n = 1'b0;
    fault_clr_i = 1'b0;
    apply(MEM_NOP, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check("reset_fault_valid", {31'b0, fault_valid_o}, 32'h0);
    check("reset_fault_addr", fault_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // loads: byte
    apply(LB,  32'h100, 32'h0, 32'h89ABCD12, 1'b0); check("lb_off0",  load_data_o, 32'h00000012);
    apply(LBU, 32'h100, 32'h0, 32'h89ABCD12, 1'b0); check("lbu_off0", load_data_o, 32'h00000012);
    apply(LB,  32'h101, 32'h0, 32'h89ABCD12, 1'b0); check("lb_off1",  load_data_o, 32'hFFFFFFCD);
    apply(LBU, 32'h101, 32'h0, 32'h89ABCD12, 1'b0); check("lbu_off1", load_data_o, 32'h000000CD);
    apply(LB,  32'h103, 32'h0, 32'h89ABCD12, 1'b0); check("lb_off3",  load_data_o, 32'hFFFFFF89);
    apply(LBU, 32'h103, 32'h0, 32'h89ABCD12, 1'b0); check("lbu_off3", load_data_o, 32'h00000089);
    apply(LB,  32'h100, 32'h0, 32'h00000080, 1'b0); check("lb_0x80",  load_data_o, 32'hFFFFFF80);
    apply(LB,  32'h100, 32'h0, 32'h0000007F, 1'b0); check("lb_0x7f",  load_data_o, 32'h0000007F);
    // loads: half / word / nop
    apply(LH,  32'h200, 32'h0, 32'h89AB7D12, 1'b0); check("lh_off0",  load_data_o, 32'h00007D12);
    apply(LH,  32'h202, 32'h0, 32'h89AB7D12, 1'b0); check("lh_off2",  load_data_o, 32'hFFFF89AB);
    apply(LHU, 32'h200, 32'h0, 32'h89ABCD12, 1'b0); check("lhu_off0", load_data_o, 32'h0000CD12);
    apply(LHU, 32'h202, 32'h0, 32'h89ABCD12, 1'b0); check("lhu_off2", load_data_o, 32'h000089AB);
    apply(LH,  32'h200, 32'h0, 32'h00008000, 1'b0); check("lh_0x8000", load_data_o, 32'hFFFF8000);
    apply(LW,  32'h4,   32'h0, 32'hDEADBEEF, 1'b0); check("lw",       load_data_o, 32'hDEADBEEF);
    apply(MEM_NOP, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("nop_load", load_data_o, 32'h0);
    check("nop_wstrb", {28'b0, wstrb}, 32'h0);
    // stores
    apply(SB, 32'h300, 32'h12345678, 32'h0, 1'b1);
    check("sb_off0_data", store_data_o, 32'h00000078); check("sb_off0_strb", {28'b0, wstrb}, 32'h1);
    apply(SB, 32'h301, 32'h12345678, 32'h0, 1'b1);
    check("sb_off1_data", store_data_o, 32'h00007800); check("sb_off1_strb", {28'b0, wstrb}, 32'h2);
    apply(SH, 32'h300, 32'hABCDEF01, 32'h0, 1'b1);
    check("sh_off0_data", store_data_o, 32'h0000EF01); check("sh_off0_strb", {28'b0, wstrb}, 32'h3);
    apply(SH, 32'h302, 32'hABCDEF01, 32'h0, 1'b1);
    check("sh_off2_data", store_data_o, 32'hEF010000); check("sh_off2_strb", {28'b0, wstrb}, 32'hC);
    apply(SW, 32'h300, 32'hFEDCBA98, 32'h0, 1'b1);
    check("sw_data", store_data_o, 32'hFEDCBA98); check("sw_strb", {28'b0, wstrb}, 32'hF);
    apply(SW, 32'h300, 32'hFEDCBA98, 32'h0, 1'b0);
    check("sw_we0_strb", {28'b0, wstrb}, 32'h0);
    check("no_fault_yet", {31'b0, fault_valid_o}, 32'h0);

    // misalignment and fault capture
    @(negedge clk);
    apply(SH, 32'h1001, 32'hABCDEF01, 32'h0, 1'b1);
    check("sh_mis_flag", {31'b0, misalign_o}, 32'h1);
    check("sh_mis_strb", {28'b0, wstrb}, 32'h0);
    @(posedge clk); #1;
    check("cap_valid", {31'b0, fault_valid_o}, 32'h1);
    check("cap_addr", fault_addr_o, 32'h00001001);
    @(negedge clk);
    apply(LW, 32'h2002, 32'h0, 32'h12345678, 1'b0);
    check("lw_mis_flag", {31'b0, misalign_o}, 32'h1);
    check("lw_mis_load", load_data_o, 32'h0);
    @(posedge clk); #1;
    check("cap_hold_addr", fault_addr_o, 32'h00001001);
    @(negedge clk);
    fault_clr_i = 1'b1;   // clear beats the still-present misaligned LW
    @(posedge clk); #1;
    check("clr_valid", {31'b0, fault_valid_o}, 32'h0);
    @(negedge clk);
    fault_clr_i = 1'b0;
    @(posedge clk); #1;
    check("recap_valid", {31'b0, fault_valid_o}, 32'h1);
    check("recap_addr", fault_addr_o, 32'h00002002);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, fault_valid_o}, 32'h0);
    check("async_rst_addr", fault_addr_o, 32'h0);
    apply(LBU, 32'h101, 32'h0, 32'h89ABCD12, 1'b0);
    check("rst_comb_load", load_data_o, 32'h000000CD);
    apply(SB, 32'h303, 32'h000000A5, 32'h0, 1'b1);
    check("rst_comb_store", store_data_o, 32'hA5000000);
    check("rst_comb_strb", {28'b0, wstrb}, 32'h8);
    apply(MEM_NOP, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the model
    m_valid = 1'b0;
    m_addr  = 32'h0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      t_rand = int'($urandom_range(0, 15));
      fault_clr_i = ($urandom_range(0, 9) == 0);
      apply(4'(t_rand), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      model(t_rand, addr, store_data_i, load_data_i, dram_we, e_ld, e_sd, e_strb, e_mis);
      exp_q.push_back(e_ld);
      exp_q.push_back(e_sd);
      exp_q.push_back({28'b0, e_strb});
      exp_q.push_back({31'b0, e_mis});
      check("rnd_load",  load_data_o,            exp_q.pop_front());
      check("rnd_store", store_data_o,           exp_q.pop_front());
      check("rnd_wstrb", {28'b0, wstrb},         exp_q.pop_front());
      check("rnd_mis",   {31'b0, misalign_o},    exp_q.pop_front());
      if (fault_clr_i) m_valid = 1'b0;
      else if (e_mis && !m_valid) begin
        m_valid = 1'b1;
        m_addr  = addr;
      end
      @(posedge clk); #1;
      check("rnd_fault_valid", {31'b0, fault_valid_o}, {31'b0, m_valid});
      check("rnd_fault_addr", fault_addr_o, m_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
